// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one port of a latency-configurable RAM among
// NUM_REQ requesters. Issues one registered memory command per cycle, and uses
// tagged shift pipelines to route read data and write acks back to their issuer.
// Optional macro RAW_HAZARD_CHK_EN: hold off reads that hit a pending write.
module ram_port_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned WR_LATENCY = 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ-1:0]            i_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_din,
  output logic [NUM_REQ-1:0]            o_gnt,
  output logic [NUM_REQ-1:0]            o_rvalid,
  output logic [DATA_WIDTH-1:0]         o_rdata,
  output logic [NUM_REQ-1:0]            o_wack,
  output logic                          o_busy,
  output logic                          o_mem_en,
  output logic                          o_mem_we,
  output logic [ADDR_WIDTH-1:0]         o_mem_addr,
  output logic [DATA_WIDTH-1:0]         o_mem_din,
  input  logic [DATA_WIDTH-1:0]         i_mem_dout
);

  localparam int unsigned IDX_W    = $clog2(NUM_REQ);
  localparam int unsigned RD_DEPTH = RD_LATENCY + 2;
  localparam int unsigned WR_DEPTH = WR_LATENCY + 1;

  typedef logic [IDX_W-1:0] idx_t;

  idx_t                  ptr_q;
  logic                  mem_en_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_din_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  // Stage s of each pipeline describes a command granted s+1 cycles ago.
  logic [RD_DEPTH-1:0]   rd_vld_q;
  idx_t                  rd_idx_q [RD_DEPTH];
  logic [WR_DEPTH-1:0]   wr_vld_q;
  idx_t                  wr_idx_q [WR_DEPTH];
`ifdef RAW_HAZARD_CHK_EN
  logic [ADDR_WIDTH-1:0] wr_addr_q [WR_DEPTH];
`endif

  logic [NUM_REQ-1:0]    elig;
  logic [NUM_REQ-1:0]    gnt_vec;
  logic                  gnt_any;
  idx_t                  gnt_idx;
  idx_t                  cand;
  logic                  win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_din;

  // Eligibility: raw requests, optionally masking reads that hit a pending write
  always_comb begin
    elig = i_req;
`ifdef RAW_HAZARD_CHK_EN
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (i_req[k] && !i_we[k]) begin
        for (int unsigned s = 0; s < WR_DEPTH; s++) begin
          if (wr_vld_q[s] && (wr_addr_q[s] == i_addr[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
            elig[k] = 1'b0;
          end
        end
      end
    end
`endif
  end

  // Round-robin search from the pointer, then select the winner's command fields
  always_comb begin
    gnt_vec  = '0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    cand     = '0;
    win_we   = 1'b0;
    win_addr = '0;
    win_din  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = idx_t'((ptr_q + i) % NUM_REQ);
      if (!gnt_any && elig[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    // No grant may be observed while reset is asserted.
    if (!i_rst_n) begin
      gnt_any = 1'b0;
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      gnt_vec[k] = gnt_any && (gnt_idx == idx_t'(k));
      if (gnt_vec[k]) begin
        win_we   = i_we[k];
        win_addr = i_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        win_din  = i_din[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Pointer advance and registered memory command
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q      <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
    end else begin
      mem_en_q <= gnt_any;
      mem_we_q <= gnt_any & win_we;
      if (gnt_any) begin
        mem_addr_q <= win_addr;
        mem_din_q  <= win_din;
        ptr_q      <= (gnt_idx == idx_t'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  // Read tag pipeline and read-data capture one stage before the valid pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_vld_q <= '0;
      rdata_q  <= '0;
      for (int unsigned s = 0; s < RD_DEPTH; s++) begin
        rd_idx_q[s] <= '0;
      end
    end else begin
      rd_vld_q    <= {rd_vld_q[RD_DEPTH-2:0], gnt_any & ~win_we};
      rd_idx_q[0] <= gnt_idx;
      for (int unsigned s = 1; s < RD_DEPTH; s++) begin
        rd_idx_q[s] <= rd_idx_q[s-1];
      end
      if (rd_vld_q[RD_LATENCY]) begin
        rdata_q <= i_mem_dout;
      end
    end
  end

  // Write tag pipeline; the last stage is the ack cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_vld_q <= '0;
      for (int unsigned s = 0; s < WR_DEPTH; s++) begin
        wr_idx_q[s] <= '0;
`ifdef RAW_HAZARD_CHK_EN
        wr_addr_q[s] <= '0;
`endif
      end
    end else begin
      wr_vld_q    <= {wr_vld_q[WR_DEPTH-2:0], gnt_any & win_we};
      wr_idx_q[0] <= gnt_idx;
`ifdef RAW_HAZARD_CHK_EN
      wr_addr_q[0] <= win_addr;
`endif
      for (int unsigned s = 1; s < WR_DEPTH; s++) begin
        wr_idx_q[s] <= wr_idx_q[s-1];
`ifdef RAW_HAZARD_CHK_EN
        wr_addr_q[s] <= wr_addr_q[s-1];
`endif
      end
    end
  end

  // Decode the final pipeline stages into one-hot return pulses
  always_comb begin
    o_rvalid = '0;
    o_wack   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      o_rvalid[k] = rd_vld_q[RD_DEPTH-1] && (rd_idx_q[RD_DEPTH-1] == idx_t'(k));
      o_wack[k]   = wr_vld_q[WR_DEPTH-1] && (wr_idx_q[WR_DEPTH-1] == idx_t'(k));
    end
  end

  assign o_gnt      = gnt_vec;
  assign o_rdata    = rdata_q;
  assign o_busy     = (|rd_vld_q) | (|wr_vld_q) | mem_en_q;
  assign o_mem_en   = mem_en_q;
  assign o_mem_we   = mem_we_q;
  assign o_mem_addr = mem_addr_q;
  assign o_mem_din  = mem_din_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: random requesters, a transaction-level
// reference (round-robin order plus a shadow memory), and a decoupled monitor.
module tb_ram_port_arbiter;

  localparam int unsigned NR  = 4;
  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 4;
  localparam int unsigned RDL = 2;
  localparam int unsigned WRL = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req, we;
  logic [NR*AW-1:0]  addr;
  logic [NR*DW-1:0]  din;
  logic [NR-1:0]     gnt, rvalid, wack;
  logic [DW-1:0]     rdata, mem_din, mem_dout;
  logic              busy, mem_en, mem_we;
  logic [AW-1:0]     mem_addr;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(RDL), .WR_LATENCY(WRL)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_addr(addr), .i_din(din),
    .o_gnt(gnt), .o_rvalid(rvalid), .o_rdata(rdata), .o_wack(wack), .o_busy(busy),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_din(mem_din),
    .i_mem_dout(mem_dout)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM port model: write commits at the command edge, read data after RDL edges
  logic [DW-1:0] ram [2**AW];
  logic [DW-1:0] dly [RDL];
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 2**AW; i++) ram[i] <= DW'($urandom);
    end else if (mem_en && mem_we) begin
      ram[mem_addr] <= mem_din;
    end
    dly[0] <= ram[mem_addr];
    for (int i = 1; i < RDL; i++) dly[i] <= dly[i-1];
  end
  assign mem_dout = dly[RDL-1];

  typedef struct { int due; int gcyc; int idx; logic [DW-1:0] data; } ret_t;
  typedef struct { int due; logic we; logic [AW-1:0] addr; logic [DW-1:0] din; } cmd_t;
  typedef struct { int due; logic [AW-1:0] addr; } pw_t;

  ret_t rdq[$];
  ret_t wrq[$];
  cmd_t cmdq[$];
  pw_t  pwq[$];

  int vectors = 0;
  int errors  = 0;

  // Requester agents and reference state
  logic [NR-1:0] pend;
  logic          we_r   [NR];
  logic [AW-1:0] addr_r [NR];
  logic [DW-1:0] din_r  [NR];
  logic [DW-1:0] shadow [2**AW];
  logic [DW-1:0] last_rdata;
  int            ptr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive();
    req = pend;
    for (int k = 0; k < NR; k++) begin
      we[k]          = we_r[k];
      addr[k*AW +: AW] = addr_r[k];
      din[k*DW +: DW]  = din_r[k];
    end
  endtask

  function automatic logic eligible(input int c);
    logic ok;
    ok = pend[c];
`ifdef RAW_HAZARD_CHK_EN
    if (ok && !we_r[c]) begin
      foreach (pwq[i]) if (pwq[i].due >= cyc && pwq[i].addr == addr_r[c]) ok = 1'b0;
    end
`endif
    return ok;
  endfunction

  // One cycle: refresh idle requesters, predict the grant, record expected returns
  task automatic step(input int pct, input int we_pct, input int amax);
    int           w;
    logic [NR-1:0] exp_gnt;
    cmd_t         c;
    ret_t         r;
    pw_t          p;
    @(posedge clk); #1;
    for (int k = 0; k < NR; k++) begin
      if (!pend[k] && int'($urandom_range(99)) < pct) begin
        pend[k]   = 1'b1;
        we_r[k]   = int'($urandom_range(99)) < we_pct;
        addr_r[k] = AW'($urandom_range(amax));
        din_r[k]  = DW'($urandom);
      end
    end
    drive();
    @(negedge clk);
    while (pwq.size() > 0 && pwq[0].due < cyc) void'(pwq.pop_front());
    w = -1;
    for (int i = 0; i < NR; i++) begin
      if (w < 0 && eligible((ptr + i) % NR)) w = (ptr + i) % NR;
    end
    exp_gnt = '0;
    if (w >= 0) exp_gnt[w] = 1'b1;
    check("gnt", 64'(gnt), 64'(exp_gnt));
    if (w >= 0) begin
      ptr = (w + 1) % NR;
      c.due = cyc + 1; c.we = we_r[w]; c.addr = addr_r[w]; c.din = din_r[w];
      cmdq.push_back(c);
      r.gcyc = cyc; r.idx = w;
      if (we_r[w]) begin
        shadow[addr_r[w]] = din_r[w];
        r.due = cyc + 1 + WRL; r.data = '0;
        wrq.push_back(r);
        p.due = r.due; p.addr = addr_r[w];
        pwq.push_back(p);
      end else begin
        r.due = cyc + 2 + RDL; r.data = shadow[addr_r[w]];
        rdq.push_back(r);
      end
      pend[w] = 1'b0;
    end
  endtask

  task automatic run(input int n, input int pct, input int we_pct, input int amax);
    repeat (n) step(pct, we_pct, amax);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    pend  = '0;
    drive();
    #1;
    check("rst_gnt", 64'(gnt), 64'(0));
    check("rst_rvalid", 64'(rvalid), 64'(0));
    check("rst_wack", 64'(wack), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_mem_en", 64'(mem_en), 64'(0));
    check("rst_mem_we", 64'(mem_we), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_mem_din", 64'(mem_din), 64'(0));
    check("rst_rdata", 64'(rdata), 64'(0));
    rdq.delete(); wrq.delete(); cmdq.delete(); pwq.delete();
    last_rdata = '0;
    ptr        = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    // Commands cut off by reset never reached the RAM; resync the shadow copy.
    for (int i = 0; i < 2**AW; i++) shadow[i] = ram[i];
    rst_n = 1'b1;
  endtask

  // Monitor: pops expected returns and memory commands as they fall due
  ret_t          mr;
  cmd_t          mc;
  logic          exp_busy;
  logic [NR-1:0] exp_rv, exp_wa;
  always @(negedge clk) begin
    if (rst_n) begin
      exp_busy = 1'b0;
      foreach (rdq[i]) if (rdq[i].gcyc < cyc) exp_busy = 1'b1;
      foreach (wrq[i]) if (wrq[i].gcyc < cyc) exp_busy = 1'b1;
      check("busy", 64'(busy), 64'(exp_busy));
      if (cmdq.size() > 0 && cmdq[0].due == cyc) begin
        mc = cmdq.pop_front();
        check("mem_en", 64'(mem_en), 64'(1));
        check("mem_we", 64'(mem_we), 64'(mc.we));
        check("mem_addr", 64'(mem_addr), 64'(mc.addr));
        if (mc.we) check("mem_din", 64'(mem_din), 64'(mc.din));
      end else begin
        check("mem_en_idle", 64'(mem_en), 64'(0));
        check("mem_we_idle", 64'(mem_we), 64'(0));
      end
      exp_rv = '0;
      if (rdq.size() > 0 && rdq[0].due == cyc) begin
        mr = rdq.pop_front();
        exp_rv[mr.idx] = 1'b1;
        last_rdata = mr.data;
      end
      check("rvalid", 64'(rvalid), 64'(exp_rv));
      check("rdata", 64'(rdata), 64'(last_rdata));
      exp_wa = '0;
      if (wrq.size() > 0 && wrq[0].due == cyc) begin
        mr = wrq.pop_front();
        exp_wa[mr.idx] = 1'b1;
      end
      check("wack", 64'(wack), 64'(exp_wa));
    end
  end

  initial begin
    rst_n      = 1'b0;
    pend       = '0;
    ptr        = 0;
    last_rdata = '0;
    for (int k = 0; k < NR; k++) begin
      we_r[k] = 1'b0; addr_r[k] = '0; din_r[k] = '0;
    end
    drive();
    do_reset();
    run(200, 100, 0, 15);   // all requesters hold reads: strict rotation
    run(400, 50, 50, 15);   // mixed traffic
    run(300, 15, 50, 15);   // sparse: pointer holds across idle cycles
    run(400, 70, 50, 1);    // two hot addresses: read-after-write pressure
    run(3, 100, 0, 15);     // reads in flight when reset hits
    do_reset();
    run(300, 60, 50, 3);
    begin
      int budget;
      budget = 0;
      while ((rdq.size() > 0 || wrq.size() > 0 || cmdq.size() > 0) && budget < 60) begin
        step(0, 0, 0);
        budget++;
      end
      step(0, 0, 0);
      vectors++;
      if (rdq.size() > 0 || wrq.size() > 0 || cmdq.size() > 0) begin
        errors++;
        $display("FAIL drain cyc=%0d outstanding=%0d expected=0", cyc,
                 rdq.size() + wrq.size() + cmdq.size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Round-robin arbiter sharing one port of the latency-configurable dual-port RAM among NUM_REQ requesters.
- Issues at most one memory command per cycle.
- Tracks the RAM's read/write latency with tagged shift pipelines so read data and write acks return to the requester that issued them.
- One instance per RAM port; the port's clock is this block's clock.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, memory data width
ADDR_WIDTH, 4, memory address width (depth 2**ADDR_WIDTH)
RD_LATENCY, 1, RAM read latency in cycles (1..8), must equal the RAM port setting
WR_LATENCY, 1, RAM write latency in cycles (1..8), must equal the RAM port setting

Ports:
i_clk  input  1  single clock
i_rst_n  input  1  asynchronous active-low reset
i_req  input  NUM_REQ  per-requester request
i_we  input  NUM_REQ  per-requester write(1)/read(0)
i_addr  input  NUM_REQ*ADDR_WIDTH  per-requester address, requester k in slice k
i_din  input  NUM_REQ*DATA_WIDTH  per-requester write data
o_gnt  output  NUM_REQ  one-hot grant, combinational, at most one bit set
o_rvalid  output  NUM_REQ  one-hot read-data-valid pulse
o_rdata  output  DATA_WIDTH  returned read data, qualified by o_rvalid
o_wack  output  NUM_REQ  one-hot write-complete pulse
o_busy  output  1  any read or write in flight
o_mem_en  output  1  to RAM port i_en
o_mem_we  output  1  to RAM port i_we
o_mem_addr  output  ADDR_WIDTH  to RAM port i_addr
o_mem_din  output  DATA_WIDTH  to RAM port i_din
i_mem_dout  input  DATA_WIDTH  from RAM port o_dout

Behaviour:
- Reset (async assert, sync release): o_gnt, o_rvalid, o_wack, o_busy, o_mem_* all 0; o_rdata 0; RR pointer 0; both tag pipelines cleared.
- Arbitration, per cycle T:
  - Among eligible requesters, grant the first at or after the RR pointer, wrapping modulo NUM_REQ.
  - o_gnt[k]=1 for that requester in cycle T.
  - Pointer becomes k+1 mod NUM_REQ at the end of T.
  - No grant in T: pointer holds.
- Handshake:
  - Requester holds req/we/addr/din stable until it sees gnt.
  - gnt lasts one cycle and consumes one command.
  - A requester holding req after gnt issues a new command.
- Memory command: registered. Grant in T → o_mem_en=1 with we/addr/din of the winner in T+1. With no grant, o_mem_en=0 and o_mem_we=0 in T+1.
- Read return:
  - Read granted in T → i_mem_dout sampled at the end of cycle T+1+RD_LATENCY.
  - Registered: o_rdata holds that value and o_rvalid[k] pulses for one cycle in T+2+RD_LATENCY.
  - o_rdata holds its last value when o_rvalid=0.
- Write ack: write granted in T → o_wack[k] pulses one cycle in T+1+WR_LATENCY.
- Pipelining: back-to-back grants every cycle are allowed; returns arrive in grant order, one per cycle. A read and a write ack may pulse in the same cycle.
- Tag pipelines: depths RD_LATENCY+2 and WR_LATENCY+1. Each stage holds {valid, requester index}.
- o_busy=1 while any stage of either pipeline is valid, or o_mem_en=1.
- Reset mid-operation: all in-flight tags are dropped; no o_rvalid or o_wack is generated for pre-reset grants.
- Requests with i_req=0 are ignored regardless of the other inputs.

Optional Feature:
- Macro RAW_HAZARD_CHK_EN.
- Defined:
  - A read request is ineligible in cycle T if its address equals the address of any write granted and not yet acked (granted in T-1..T-WR_LATENCY-1 with wack still pending).
  - Masked requesters are skipped by the RR search; they are granted once the matching wack has pulsed.
  - The write pipeline additionally stores the address.
- Undefined: no address check. A read may overtake a pending write, and the read data is whatever the RAM returns.

Test Plan:
- RD_LATENCY=2, req[1] read addr 5 (mem[5]=0xA7) granted cycle 10 → o_mem_en/addr=5 cycle 11; o_rvalid=4'b0010, o_rdata=0xA7 cycle 14.
- All four requesters hold reads continuously from reset → grants 0,1,2,3,0,1… one per cycle; o_rvalid follows the same order RD_LATENCY+2 cycles later; o_busy stays 1.
- WR_LATENCY=3, req[2] write addr 3 data 0x5C granted cycle 20 → o_mem_we=1 cycle 21, o_wack=4'b0100 cycle 24.
- With RAW_HAZARD_CHK_EN, req[0] write addr 9 granted cycle 30 and req[1] read addr 9 requesting from cycle 31 → req[1] not granted until after o_wack[0] at cycle 30+1+WR_LATENCY; its o_rdata equals the written data. Without the macro, req[1] is granted at cycle 31.
- Assert i_rst_n=0 two cycles after three reads are granted → outputs immediately 0; after release, no o_rvalid pulses and the pointer restarts at 0.
- Only req[3] requesting with pointer=1 → granted immediately; pointer becomes 0; no grant cycles hold the pointer.
